// File: rtl/dcache_ctrl_if.sv
// CPU memory-stage and data-memory signals of the data cache controller.
// master = pipeline plus memory side, slave = the cache controller.
interface dcache_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_stall;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller
// with a req/ack memory handshake and saturating hit/miss counters.
module dcache_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned IDX_BITS   = 3,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  dcache_ctrl_if.slave         bus,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
);
  localparam int unsigned SETS     = 1 << IDX_BITS;
  localparam int unsigned TAG_BITS = ADDR_WIDTH - IDX_BITS - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                state;
  logic [SETS-1:0]       valid;
  logic [TAG_BITS-1:0]   tag_mem  [SETS];
  logic [DATA_WIDTH-1:0] data_mem [SETS];

  logic [IDX_BITS-1:0]   idx, lat_idx;
  logic [TAG_BITS-1:0]   tag, lat_tag;
  logic                  hit, lat_hit, lat_load, ack_ok, line_we;
  logic [DATA_WIDTH-1:0] resp_buf, line_wdata, cpu_rdata;
  logic                  cpu_stall;
  logic                  mem_req, mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == '1) ? c : c + CNT_WIDTH'(1);
  endfunction

  assign idx     = bus.cpu_addr[IDX_BITS+1:2];
  assign tag     = bus.cpu_addr[ADDR_WIDTH-1:IDX_BITS+2];
  // The latched word address doubles as the line index/tag of the pending access.
  assign lat_idx = mem_addr[IDX_BITS+1:2];
  assign lat_tag = mem_addr[ADDR_WIDTH-1:IDX_BITS+2];
  assign hit     = bus.cpu_req & valid[idx] & (tag_mem[idx] == tag);
  assign ack_ok  = bus.mem_ack & mem_req;

  assign line_we    = !rst && ack_ok && ((state == FILL) || (state == WRITE && lat_hit));
  assign line_wdata = (state == FILL) ? bus.mem_rdata : mem_wdata;

  always_ff @(posedge clk) begin
    if (line_we) begin
      data_mem[lat_idx] <= line_wdata;
      tag_mem[lat_idx]  <= lat_tag;
    end
  end

  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    unique case (state)
      IDLE: begin
        if (bus.cpu_req) begin
          if (hit && !bus.cpu_we) cpu_rdata = data_mem[idx];
          else                    cpu_stall = 1'b1;
        end
      end
      FILL, WRITE: cpu_stall = 1'b1;
      DONE:        if (lat_load) cpu_rdata = resp_buf;
      default:     cpu_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      resp_buf  <= '0;
      lat_hit   <= 1'b0;
      lat_load  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            if (hit) hit_cnt  <= sat_inc(hit_cnt);
            else     miss_cnt <= sat_inc(miss_cnt);
            if (bus.cpu_we || !hit) begin
              mem_req  <= 1'b1;
              mem_we   <= bus.cpu_we;
              mem_addr <= {bus.cpu_addr[ADDR_WIDTH-1:2], 2'b00};
              lat_hit  <= hit;
              lat_load <= !bus.cpu_we;
              if (bus.cpu_we) begin
                mem_wdata <= bus.cpu_wdata;
                state     <= WRITE;
              end else begin
                state <= FILL;
              end
            end
          end
        end
        FILL: begin
          if (ack_ok) begin
            valid[lat_idx] <= 1'b1;
            resp_buf       <= bus.mem_rdata;
            mem_req        <= 1'b0;
            state          <= DONE;
          end
        end
        WRITE: begin
          if (ack_ok) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_stall = cpu_stall;
  assign bus.cpu_rdata = cpu_rdata;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a cache/memory reference model predicts
// each access; monitor and memory responder pop and compare independently.
module tb_dcache_ctrl;
  localparam int unsigned CW = 12;
  localparam logic [CW-1:0] CMAX = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CW-1:0] hit_cnt, miss_cnt;

  dcache_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  dcache_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .IDX_BITS(3), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int unsigned stalls;
    logic [CW-1:0] hc;
    logic [CW-1:0] mc;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned delay;
  } mreq_t;

  rsp_t  sq[$];
  mreq_t mq[$];
  int checks = 0;
  int errors = 0;

  bit          ref_valid [8];
  logic [26:0] ref_tag   [8];
  logic [31:0] ref_data  [8];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] env_mem [logic [31:0]];
  logic [CW-1:0] exp_hc = '0;
  logic [CW-1:0] exp_mc = '0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] env_read(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_word(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    exp_hc = '0;
    exp_mc = '0;
  endtask

  task automatic idle(input int unsigned n);
    bus.cpu_req = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one access; called at posedge+1, returns at posedge+1 after completion.
  task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input int unsigned delay);
    logic [31:0] wa;
    int unsigned i;
    logic [26:0] t;
    bit h;
    rsp_t r;
    mreq_t m;
    wa = {addr[31:2], 2'b00};
    i  = 32'(addr[4:2]);
    t  = addr[31:5];
    h  = ref_valid[i] && (ref_tag[i] == t);
    if (h) begin
      if (exp_hc != CMAX) exp_hc = exp_hc + 1'b1;
    end else begin
      if (exp_mc != CMAX) exp_mc = exp_mc + 1'b1;
    end
    if (!we) begin
      if (h) r.rdata = ref_data[i];
      else begin
        r.rdata      = ref_read(wa);
        ref_valid[i] = 1'b1;
        ref_tag[i]   = t;
        ref_data[i]  = r.rdata;
      end
    end else begin
      r.rdata     = '0;
      ref_mem[wa] = wdata;
      if (h) ref_data[i] = wdata;
    end
    r.stalls = (!we && h) ? 0 : delay + 2;
    r.hc = exp_hc;
    r.mc = exp_mc;
    sq.push_back(r);
    if (we || !h) begin
      m.we = we; m.addr = wa; m.wdata = wdata; m.delay = delay;
      mq.push_back(m);
    end
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (!bus.cpu_stall) break;
      if (n > 64) begin
        checks++;
        errors++;
        $display("FAIL stall_timeout: addr %h still stalled after %0d cycles", addr, n);
        finish_run();
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: completion is any cycle with cpu_req high and cpu_stall low.
  initial begin
    int unsigned run;
    bit pend;
    logic [CW-1:0] phc, pmc;
    rsp_t r;
    run = 0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0;
        pend = 1'b0;
        continue;
      end
      if (pend) begin
        check("hit_cnt", 32'(hit_cnt), 32'(phc));
        check("miss_cnt", 32'(miss_cnt), 32'(pmc));
        pend = 1'b0;
      end
      if (bus.cpu_req) begin
        if (bus.cpu_stall) run++;
        else if (sq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: addr %h with no pending access", bus.cpu_addr);
        end else begin
          r = sq.pop_front();
          check("cpu_rdata", bus.cpu_rdata, r.rdata);
          check("stall_cycles", run, r.stalls);
          phc = r.hc;
          pmc = r.mc;
          pend = 1'b1;
          run = 0;
        end
      end
    end
  end

  // Memory responder: checks each request against the model, acks after its delay.
  initial begin
    bit busy;
    int unsigned waited;
    mreq_t cur;
    busy = 1'b0;
    waited = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (rst) begin
        busy = 1'b0;
        continue;
      end
      if (bus.mem_req) begin
        if (!busy) begin
          if (mq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_mem_req: addr %h we %b", bus.mem_addr, bus.mem_we);
            cur.we = bus.mem_we; cur.addr = bus.mem_addr; cur.wdata = bus.mem_wdata; cur.delay = 0;
          end else begin
            cur = mq.pop_front();
            check("mem_we", 32'(bus.mem_we), 32'(cur.we));
            check("mem_addr", bus.mem_addr, cur.addr);
            if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
          end
          busy = 1'b1;
          waited = 0;
        end else begin
          check("mem_addr_stable", bus.mem_addr, cur.addr);
          check("mem_we_stable", 32'(bus.mem_we), 32'(cur.we));
        end
        if (waited == cur.delay) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = env_read(bus.mem_addr);
          if (bus.mem_we) env_mem[bus.mem_addr] = bus.mem_wdata;
          busy = 1'b0;
        end else begin
          waited++;
        end
      end else if (busy) begin
        checks++;
        errors++;
        $display("FAIL mem_req_dropped: addr %h before ack", cur.addr);
        busy = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end

  initial begin
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    model_reset();
    env_mem[32'h10] = 32'hDEADBEEF;
    ref_mem[32'h10] = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_stall", 32'(bus.cpu_stall), 32'h0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    check("rst_mem_req", 32'(bus.mem_req), 32'h0);
    check("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_hit_cnt", 32'(hit_cnt), 32'h0);
    check("rst_miss_cnt", 32'(miss_cnt), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    do_op(1'b0, 32'h10, 32'h0, 1);
    do_op(1'b0, 32'h10, 32'h0, 0);
    do_op(1'b1, 32'h10, 32'h12345678, 0);
    do_op(1'b0, 32'h10, 32'h0, 0);
    do_op(1'b1, 32'h30, 32'hCAFEF00D, 2);
    do_op(1'b0, 32'h30, 32'h0, 1);
    do_op(1'b0, 32'h10, 32'h0, 0);
    do_op(1'b0, 32'h30, 32'h0, 3);
    do_op(1'b0, 32'h10, 32'h0, 0);
    idle(2);

    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2)
        | 32'($urandom_range(0, 3));
      do_op(($urandom_range(0, 9) < 4), a, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 32'h1010;
    mq.push_back('{we: 1'b0, addr: 32'h1010, wdata: 32'h0, delay: 30});
    @(negedge clk);
    @(negedge clk);
    check("fill_mem_req", 32'(bus.mem_req), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_mem_req", 32'(bus.mem_req), 32'h0);
    check("midrst_cpu_stall", 32'(bus.cpu_stall), 32'h0);
    check("midrst_hit_cnt", 32'(hit_cnt), 32'h0);
    check("midrst_miss_cnt", 32'(miss_cnt), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sq.delete();
    mq.delete();
    model_reset();
    do_op(1'b0, 32'h10, 32'h0, 1);

    for (int k = 0; k < 4100; k++) do_op(1'b0, 32'h10, 32'h0, 0);
    idle(4);
    check("hit_cnt_saturated", 32'(hit_cnt), 32'(CMAX));
    check("rsp_queue_empty", sq.size(), 0);
    check("mem_queue_empty", mq.size(), 0);
    finish_run();
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller for the memory stage of the pipelined core.
- Sits between the EX/MEM pipeline register outputs (ALU result as address, write data, MemWrite) and the word-wide data memory.
- Stalls the pipeline on misses and writes.
- Talks to memory over a variable-latency req/ack handshake.
- Keeps saturating hit/miss statistics counters.

Parameters:
- DATA_WIDTH, 32, data word width.
- ADDR_WIDTH, 32, byte address width.
- IDX_BITS, 3, index width; SETS = 2**IDX_BITS lines, one word per line.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  memory-stage access valid (load or store).
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_rdata  out  DATA_WIDTH  load data.
- cpu_stall  out  1  freeze PC/FD/DE/EM/MW registers while high.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  word-aligned memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion, one-cycle pulse.
- hit_cnt  out  CNT_WIDTH  accesses that hit.
- miss_cnt  out  CNT_WIDTH  accesses that missed.

Behaviour:
- Address split: index = cpu_addr[IDX_BITS+1:2]; tag = cpu_addr[ADDR_WIDTH-1:IDX_BITS+2].
- Storage per line: valid bit, tag, data word.
- hit = cpu_req & valid[index] & (tag_array[index] == tag).
- Reset:
  - state = IDLE; all valid bits cleared; hit_cnt = miss_cnt = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0; cpu_rdata = 0; cpu_stall = 0.
  - Reset mid-transaction abandons it: mem_req is low in the cycle after the reset edge, and no line is written.
- State IDLE:
  - No request: cpu_stall = 0.
  - Load hit: cpu_rdata = line data combinationally; cpu_stall = 0; zero extra cycles; stay in IDLE.
  - Load miss: cpu_stall = 1; latch word address; next state FILL.
  - Store (hit or miss): cpu_stall = 1; latch address, data and hit flag; next state WRITE.
  - Counters: update once per access, in IDLE only. The store hit/miss is decided by tag match. Counters saturate at all-ones and never wrap.
- State FILL:
  - mem_req = 1, mem_we = 0, mem_addr = latched word address (bits [1:0] = 0); cpu_stall = 1.
  - On mem_ack: write mem_rdata into the line, set its tag, set valid; capture mem_rdata into the response buffer; next state DONE.
- State WRITE:
  - mem_req = 1, mem_we = 1, mem_addr and mem_wdata = latched values; cpu_stall = 1.
  - On mem_ack: if the latched hit flag is set, update the line data (write-through keeps it coherent). A miss leaves the cache untouched. Next state DONE.
- State DONE:
  - cpu_stall = 0 for exactly one cycle; the pipeline advances on this edge.
  - cpu_rdata = response buffer for a load, 0 for a store.
  - The request present is the one being completed: no lookup, no counter update. Next state IDLE.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are stable from the first FILL/WRITE cycle until and including the ack cycle.
  - mem_ack is honoured only while mem_req = 1. It may arrive in the first FILL/WRITE cycle.
  - mem_req drops in DONE.
- Miss latency: a load miss with ack in the first FILL cycle gives cpu_stall high for 2 cycles (IDLE, FILL), then DONE. Each extra wait cycle adds 1.
- cpu_rdata outside a load hit or load DONE: 0.
- Index aliasing: a fill overwrites any previous line at that index.

Test Plan:
- After rst, load 0x0000_0010 with memory holding 0xDEADBEEF at that word and ack after 2 cycles -> cpu_stall high for 3 cycles; DONE cycle shows cpu_rdata = 0xDEADBEEF; miss_cnt = 1.
- Load 0x0000_0010 again -> same-cycle cpu_rdata = 0xDEADBEEF, cpu_stall = 0, hit_cnt = 1.
- Store 0x12345678 to 0x10, ack in the first WRITE cycle -> mem_we = 1, mem_addr = 0x10, mem_wdata = 0x12345678; hit_cnt = 2. A following load hits with 0x12345678 and no mem_req.
- Store to 0x30 (miss) then load 0x30 -> store does not allocate (miss_cnt += 1); the load misses and fills (miss_cnt += 1).
- Load 0x10 then load 0x30 (same index 4, different tag), then 0x10 again -> all three miss; the line's tag is replaced each time.
- Assert rst during FILL before ack -> next cycle mem_req = 0, state IDLE, cpu_stall = 0, counters 0; a load of 0x10 misses.
- Preload hit_cnt to 0xFFFE via repeated hits, then 3 more hits -> hit_cnt holds at 0xFFFF.
